cmp_pipe_unit: RTL and testbench
================================

# cmp_pipe_unit

Parametrised, two-stage pipelined compare unit that replaces the single-cycle comparator in the ALU/compare datapath. It adds signed/unsigned operation, MAX/MIN selection, and running-extremum tracking over a sample stream. It accepts one operation per cycle and returns each result two cycles later with a one-cycle valid flag. It sits beside the ALU and takes operands from the register file under control of the system controller.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width
- OUT_WIDTH, 16, result width; must be >= DATA_WIDTH
- CNT_WIDTH, 8, running-sample counter width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- A  in  DATA_WIDTH  operand A
- B  in  DATA_WIDTH  operand B
- cmp_func  in  3  operation select
- cmp_signed  in  1  1 = two's-complement compare, 0 = unsigned
- cmp_enable  in  1  issue strobe; one operation accepted per high cycle
- cmp_clr  in  1  clears running-extremum state
- cmp_out  out  OUT_WIDTH  result
- cmp_count  out  CNT_WIDTH  running-sample count
- cmp_flag  out  1  result valid, one cycle per accepted operation

## Operation
- Stage 1: on a cycle with cmp_enable=1, register A, B, cmp_func, cmp_signed and a valid bit. On a cycle with cmp_enable=0, register valid=0.
- Stage 2: compute from the stage-1 registers. Register cmp_out and cmp_flag = stage-1 valid.
- cmp_func encoding:
  - 000: 0
  - 001: EQ, 1 if A==B else 0
  - 010: GT, 2 if A>B else 0
  - 011: LT, 3 if A<B else 0
  - 100: MAX(A,B)
  - 101: MIN(A,B)
  - 110: RMAX, running maximum of A
  - 111: RMIN, running minimum of A
- GT, LT, MAX, MIN, RMAX and RMIN use the signed or unsigned ordering selected by cmp_signed.
- Width rule: a data result is zero-extended to OUT_WIDTH when cmp_signed=0 and sign-extended when cmp_signed=1. Constant codes 1/2/3 are zero-extended.
- Running state: max_reg, min_reg (DATA_WIDTH), cnt_reg (CNT_WIDTH). Reset value is 0. Both extremum registers update on every 110 or 111 sample.
  - First sample (cnt_reg==0): max_reg = min_reg = A, cnt_reg = 1.
  - Later samples: max_reg = max(max_reg, A), min_reg = min(min_reg, A).
  - cnt_reg increments and saturates at all-ones.
  - Result is the updated max_reg (110) or updated min_reg (111).
- cmp_count always shows cnt_reg.
- cmp_clr is not pipelined. It zeroes cnt_reg, max_reg and min_reg at the next edge.
- If cmp_clr is high while a running sample is in stage 2, the clear applies first and that sample is processed as a first sample (count=1).
- Non-running operations never modify the running state.
- When cmp_flag=0, cmp_out=0.

## Timing
- Latency: issue at edge n gives the result and cmp_flag=1 after edge n+2. Throughput is 1 operation/cycle with no stalls and no backpressure.
- Back-to-back running samples need no hazard logic, because the running state is read and written only in stage 2.
- Reset values: cmp_out=0, cmp_flag=0, cmp_count=0. All pipeline valids and running registers are 0.
- Reset asserted mid-operation discards all in-flight operations. No flag is produced for them after reset release.
- A mode or cmp_signed change between consecutive operations takes effect per operation, because these values are carried down the pipeline.

## Configuration
- CMP_RUNNING_EN defined: codes 110/111 behave as specified, and the running registers exist.
- CMP_RUNNING_EN undefined:
  - Codes 110/111 return 0 with cmp_flag=1.
  - cmp_count is tied to 0 and cmp_clr is ignored.
  - No running registers are synthesised.

## Structure
- Shared package cmp_pkg holds:
  - the cmp_func localparams (CMP_NOP, CMP_EQ, CMP_GT, CMP_LT, CMP_MAX, CMP_MIN, CMP_RMAX, CMP_RMIN)
  - the constant result codes 1/2/3
- Sub-module cmp_order: a combinational signed/unsigned comparator with outputs eq, gt, lt.
  - One instance for A vs B.
  - One instance for A vs max_reg and A vs min_reg (two instances when CMP_RUNNING_EN is defined).

## Test plan
- Reset mid-stream: issue EQ A=5 B=5, assert rst the next cycle → cmp_flag never rises; after release, all outputs are 0.
- Unsigned compares: EQ 5/5, GT 9/3, LT 3/9 on consecutive cycles → cmp_out 1, 2, 3 on three consecutive cycles, each 2 cycles after issue, cmp_flag high for all three.
- Signed vs unsigned: A=8'hFF, B=8'h01, MAX with cmp_signed=0 → 16'h00FF; same with cmp_signed=1 → 16'h0001; MIN with cmp_signed=1 → 16'hFFFF.
- Running stream:
  - RMAX samples 4, 10, 7 → 4, 10, 10, with cmp_count 1, 2, 3.
  - Then RMIN A=7 → 4, cmp_count 4.
  - cmp_clr plus RMAX A=2 in stage 2 → 2, cmp_count 1.
- Counter saturation: CNT_WIDTH=2, five RMIN samples → cmp_count 1, 2, 3, 3, 3.
- Macro off: without CMP_RUNNING_EN, RMAX A=9 → cmp_out 0, cmp_flag 1, cmp_count 0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the pipelined compare unit:
// operation select codes and constant compare result codes.
package cmp_pkg;

    localparam logic [2:0] CMP_NOP  = 3'b000;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_GT   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b011;
    localparam logic [2:0] CMP_MAX  = 3'b100;
    localparam logic [2:0] CMP_MIN  = 3'b101;
    localparam logic [2:0] CMP_RMAX = 3'b110;
    localparam logic [2:0] CMP_RMIN = 3'b111;

    localparam logic [1:0] RES_EQ = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;
    localparam logic [1:0] RES_LT = 2'd3;

endpackage

// File: rtl/cmp_pipe_unit_order.sv
// Combinational signed/unsigned magnitude comparator.
// Module name: cmp_order.
module cmp_order #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    always_comb begin
        eq = (a == b);
        if (sgn) begin
            gt = ($signed(a) > $signed(b));
            lt = ($signed(a) < $signed(b));
        end else begin
            gt = (a > b);
            lt = (a < b);
        end
    end

endmodule

// File: rtl/cmp_pipe_unit.sv
// Two-stage pipelined compare unit with MAX/MIN and running extremum.
// Running extremum (codes 110/111) is built only with CMP_RUNNING_EN.
module cmp_pipe_unit
    import cmp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            cmp_func,
    input  logic                  cmp_signed,
    input  logic                  cmp_enable,
    input  logic                  cmp_clr,
    output logic [OUT_WIDTH-1:0]  cmp_out,
    output logic [CNT_WIDTH-1:0]  cmp_count,
    output logic                  cmp_flag
);

    function automatic logic [OUT_WIDTH-1:0] ext(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  s
    );
        if (s) ext = OUT_WIDTH'($signed(d));
        else   ext = OUT_WIDTH'(d);
    endfunction

    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            func_q, func_d;
    logic                  sgn_q, sgn_d;
    logic                  vld1_q, vld1_d;

    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic                  flag_q, flag_d;

    logic                  ab_eq, ab_gt, ab_lt;
    logic [DATA_WIDTH-1:0] rmax_res, rmin_res;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        func_d = func_q;
        sgn_d  = sgn_q;
        vld1_d = cmp_enable;
        if (cmp_enable) begin
            a_d    = A;
            b_d    = B;
            func_d = cmp_func;
            sgn_d  = cmp_signed;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            func_q <= CMP_NOP;
            sgn_q  <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            func_q <= func_d;
            sgn_q  <= sgn_d;
            vld1_q <= vld1_d;
        end
    end

    cmp_order #(.W(DATA_WIDTH)) u_ab (
        .a   (a_q),
        .b   (b_q),
        .sgn (sgn_q),
        .eq  (ab_eq),
        .gt  (ab_gt),
        .lt  (ab_lt)
    );

`ifdef CMP_RUNNING_EN
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] min_q, min_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_base;
    logic                  run_hit, first;
    logic                  mx_gt, mn_lt;
    logic                  mx_eq_unused, mx_lt_unused;
    logic                  mn_eq_unused, mn_gt_unused;

    cmp_order #(.W(DATA_WIDTH)) u_max (
        .a   (a_q),
        .b   (max_q),
        .sgn (sgn_q),
        .eq  (mx_eq_unused),
        .gt  (mx_gt),
        .lt  (mx_lt_unused)
    );

    cmp_order #(.W(DATA_WIDTH)) u_min (
        .a   (a_q),
        .b   (min_q),
        .sgn (sgn_q),
        .eq  (mn_eq_unused),
        .gt  (mn_gt_unused),
        .lt  (mn_lt)
    );

    // A clear coinciding with a sample makes that sample the first one.
    always_comb begin
        run_hit  = vld1_q && (func_q == CMP_RMAX || func_q == CMP_RMIN);
        cnt_base = cmp_clr ? '0 : cnt_q;
        first    = (cnt_base == '0);
        max_d    = cmp_clr ? '0 : max_q;
        min_d    = cmp_clr ? '0 : min_q;
        cnt_d    = cnt_base;
        if (run_hit) begin
            if (first) begin
                max_d = a_q;
                min_d = a_q;
                cnt_d = CNT_WIDTH'(1);
            end else begin
                if (mx_gt) max_d = a_q;
                if (mn_lt) min_d = a_q;
                if (cnt_base != '1) cnt_d = cnt_base + 1'b1;
            end
        end
        rmax_res = max_d;
        rmin_res = min_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            min_q <= '0;
            cnt_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            cnt_q <= cnt_d;
        end
    end

    assign cmp_count = cnt_q;
`else
    logic clr_unused;

    assign clr_unused = cmp_clr;
    assign rmax_res   = '0;
    assign rmin_res   = '0;
    assign cmp_count  = '0;
`endif

    always_comb begin
        out_d = '0;
        unique case (func_q)
            CMP_NOP:  out_d = '0;
            CMP_EQ:   out_d = ab_eq ? OUT_WIDTH'(RES_EQ) : '0;
            CMP_GT:   out_d = ab_gt ? OUT_WIDTH'(RES_GT) : '0;
            CMP_LT:   out_d = ab_lt ? OUT_WIDTH'(RES_LT) : '0;
            CMP_MAX:  out_d = ext(ab_gt ? a_q : b_q, sgn_q);
            CMP_MIN:  out_d = ext(ab_lt ? a_q : b_q, sgn_q);
            CMP_RMAX: out_d = ext(rmax_res, sgn_q);
            CMP_RMIN: out_d = ext(rmin_res, sgn_q);
        endcase
        if (!vld1_q) out_d = '0;
        flag_d = vld1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            flag_q <= flag_d;
        end
    end

    assign cmp_out  = out_q;
    assign cmp_flag = flag_q;

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Scoreboard bench for cmp_pipe_unit; expected results queued at issue,
// popped by a monitor on every flagged output.
module tb_cmp_pipe_unit;
    import cmp_pkg::*;

    typedef struct {
        logic [15:0] out;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  A, B;
    logic [2:0]  cmp_func;
    logic        cmp_signed, cmp_enable, cmp_clr;
    logic [15:0] cmp_out;
    logic [7:0]  cmp_count;
    logic        cmp_flag;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    cmp_pipe_unit #(
        .DATA_WIDTH (8),
        .OUT_WIDTH  (16),
        .CNT_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .cmp_func   (cmp_func),
        .cmp_signed (cmp_signed),
        .cmp_enable (cmp_enable),
        .cmp_clr    (cmp_clr),
        .cmp_out    (cmp_out),
        .cmp_count  (cmp_count),
        .cmp_flag   (cmp_flag)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            total += 3;
            if (cmp_out !== 16'h0) begin
                bad++; $display("FAIL rst_out got=%h want=0", cmp_out);
            end
            if (cmp_flag !== 1'b0) begin
                bad++; $display("FAIL rst_flag got=%b want=0", cmp_flag);
            end
            if (cmp_count !== 8'h0) begin
                bad++; $display("FAIL rst_cnt got=%h want=0", cmp_count);
            end
        end else if (cmp_flag === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL spurious_flag got=1 want=0 out=%h cyc=%0d",
                         cmp_out, cyc);
            end else begin
                e = q.pop_front();
                total += 2;
                if (cmp_out !== e.out) begin
                    bad++;
                    $display("FAIL out cyc=%0d got=%h want=%h",
                             cyc, cmp_out, e.out);
                end
                if (cmp_count !== e.cnt) begin
                    bad++;
                    $display("FAIL count cyc=%0d got=%0d want=%0d",
                             cyc, cmp_count, e.cnt);
                end
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL latency got_cyc=%0d want_cyc=%0d",
                             cyc, e.cyc);
                end
            end
        end else begin
            total++;
            if (cmp_out !== 16'h0) begin
                bad++;
                $display("FAIL idle_out got=%h want=0", cmp_out);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [7:0] a,
                         input logic [7:0] b, input logic s,
                         input logic [15:0] eo, input logic [7:0] ec,
                         input bit push);
        exp_t e;
        A = a; B = b; cmp_func = f; cmp_signed = s; cmp_enable = 1;
        if (push) begin
            e.out = eo; e.cnt = ec; e.cyc = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk); #1;
        cmp_enable = 0;
    endtask

    task automatic idle(input int n);
        cmp_enable = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 0; A = 0; B = 0; cmp_func = 0;
        cmp_signed = 0; cmp_enable = 0; cmp_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        idle(2);

        // reset mid-flight: issued EQ must never flag
        issue(CMP_EQ, 8'd5, 8'd5, 0, 16'h0, 8'd0, 0);
        rst = 0;
        idle(3);
        rst = 1;
        idle(4);

        issue(CMP_EQ, 8'd5, 8'd5, 0, 16'h0001, 8'd0, 1);
        issue(CMP_GT, 8'd9, 8'd3, 0, 16'h0002, 8'd0, 1);
        issue(CMP_LT, 8'd3, 8'd9, 0, 16'h0003, 8'd0, 1);
        issue(CMP_EQ, 8'd5, 8'd6, 0, 16'h0000, 8'd0, 1);
        issue(CMP_GT, 8'hFF, 8'h01, 1, 16'h0000, 8'd0, 1);
        issue(CMP_LT, 8'hFF, 8'h01, 1, 16'h0003, 8'd0, 1);
        issue(CMP_GT, 8'hFF, 8'h01, 0, 16'h0002, 8'd0, 1);
        issue(CMP_MAX, 8'hFF, 8'h01, 0, 16'h00FF, 8'd0, 1);
        issue(CMP_MAX, 8'hFF, 8'h01, 1, 16'h0001, 8'd0, 1);
        issue(CMP_MIN, 8'hFF, 8'h01, 1, 16'hFFFF, 8'd0, 1);
        issue(CMP_MIN, 8'hFF, 8'h01, 0, 16'h0001, 8'd0, 1);
        issue(CMP_NOP, 8'h12, 8'h34, 0, 16'h0000, 8'd0, 1);
        idle(3);

`ifdef CMP_RUNNING_EN
        issue(CMP_RMAX, 8'd4, 8'd0, 0, 16'd4, 8'd1, 1);
        issue(CMP_RMAX, 8'd10, 8'd0, 0, 16'd10, 8'd2, 1);
        issue(CMP_RMAX, 8'd7, 8'd0, 0, 16'd10, 8'd3, 1);
        issue(CMP_RMIN, 8'd7, 8'd0, 0, 16'd4, 8'd4, 1);
        issue(CMP_EQ, 8'd1, 8'd1, 0, 16'd1, 8'd4, 1);
        idle(2);
        // clear lands while RMAX 2 is in stage 2
        issue(CMP_RMAX, 8'd2, 8'd0, 0, 16'd2, 8'd1, 1);
        cmp_clr = 1;
        @(posedge clk); #1;
        cmp_clr = 0;
        idle(2);
        issue(CMP_RMIN, 8'h80, 8'd0, 1, 16'hFF80, 8'd2, 1);
        idle(2);
        cmp_clr = 1;
        @(posedge clk); #1;
        cmp_clr = 0;
        idle(2);
        for (int i = 0; i < 260; i++) begin
            logic [7:0] a8;
            a8 = 8'(i);
            issue(CMP_RMAX, a8, 8'd0, 0,
                  (i < 256) ? 16'(i) : 16'd255,
                  (i < 255) ? 8'(i + 1) : 8'd255, 1);
        end
        idle(3);
`else
        issue(CMP_RMAX, 8'd9, 8'd0, 0, 16'd0, 8'd0, 1);
        issue(CMP_RMIN, 8'd3, 8'd0, 1, 16'd0, 8'd0, 1);
        cmp_clr = 1;
        issue(CMP_RMAX, 8'hF0, 8'd0, 0, 16'd0, 8'd0, 1);
        cmp_clr = 0;
        idle(3);
`endif

        for (int k = 0; k < 10 && q.size() != 0; k++) idle(1);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got_pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
